// File: rtl/work_scheduler.sv
// work_scheduler
//   Latches each 352-bit work unit from the serial block and shares it with NUM_CORES
//   hashing cores. Each core gets a fixed slice of the 32-bit nonce space. All cores
//   start together. Found-nonce reports are arbitrated round-robin into a result FIFO,
//   and the FIFO drains to the serial result port.
//
//   Optional feature: define DROP_CNT_EN to add the drop_count output. It counts
//   overwritten pending results and saturates at 16'hFFFF.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   new_block, block  1-cycle strobe carrying a new 352-bit work unit
//   core_start        1-cycle start pulse to every core
//   core_block        latched work unit shared by all cores
//   core_nonce_base   constant per-core base nonce, core i at slice i
//   core_found        per-core found strobe; core_nonce slice i is valid with it
//   core_done         per-core level, high when that core has exhausted its range
//   result_valid/     FIFO head; holds a nonce or the 32'hFFFF_FFFF exhaustion marker
//   result_data
//   result_ready      consumer accept
//   state_dbg_o       current FSM state (IDLE=0 LOAD=1 START=2 RUN=3 DONE=4)
//   drop_count        overwritten-result counter (DROP_CNT_EN only)
//
// Handshake: a result word transfers on every rising edge where result_valid and
// result_ready are both high. result_data holds steady while valid is high and ready
// is low.

module work_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    new_block,
    input  logic [351:0]            block,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [351:0]            core_block,
    output logic [32*NUM_CORES-1:0] core_nonce_base,
    input  logic [NUM_CORES-1:0]    core_found,
    input  logic [32*NUM_CORES-1:0] core_nonce,
    input  logic [NUM_CORES-1:0]    core_done,
    output logic                    result_valid,
    output logic [31:0]             result_data,
    input  logic                    result_ready,
    output logic [2:0]              state_dbg_o
`ifdef DROP_CNT_EN
    ,
    output logic [15:0]             drop_count
`endif
);

    localparam int IW         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int BASE_SHIFT = 32 - $clog2(NUM_CORES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q;
    logic [NUM_CORES-1:0]   core_start_q;
    logic [351:0]           core_block_q;
    logic [NUM_CORES-1:0]   pending_q;
    logic [NUM_CORES-1:0]   pending_d;
    logic [31:0]            nonce_q [NUM_CORES];
    logic [IW-1:0]          rr_q;
    logic [IW-1:0]          rr_d;
    logic [31:0]            mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q;
    logic [PW-1:0]          rd_ptr_q;
    logic [CW-1:0]          count_q;

    // Base nonces: the 32-bit space is split into NUM_CORES equal slices.
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_base
        assign core_nonce_base[g*32 +: 32] = 32'(g) << BASE_SHIFT;
    end

    assign core_start   = core_start_q;
    assign core_block   = core_block_q;
    assign state_dbg_o  = state_q;

    logic fifo_empty, fifo_full, pop, slot_ok;
    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == CW'(FIFO_DEPTH));
    assign result_valid = !fifo_empty;
    assign result_data  = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
    assign pop          = result_valid && result_ready;
    // A full FIFO can still accept a word when its head leaves on the same edge.
    assign slot_ok      = !fifo_full || pop;

    // A new_block cycle flushes everything, so it suppresses capture and enqueue.
    logic run_active;
    assign run_active = (state_q == S_RUN) && !new_block;

    // Round-robin search: first pending index at or after rr_q, wrapping.
    logic          grant_found;
    logic [IW-1:0] grant_idx;
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = (int'(rr_q) + k) % NUM_CORES;
            if (!grant_found && pending_q[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end

    logic                 do_grant, do_marker, push;
    logic [31:0]          push_data;
    logic [NUM_CORES-1:0] granted_vec, found_run, drop_vec;

    assign do_grant    = run_active && grant_found && slot_ok;
    // pending_q is zero whenever the marker fires, so it never competes with a grant.
    assign do_marker   = run_active && (&core_done) && (pending_q == '0) && slot_ok;
    assign push        = do_grant || do_marker;
    assign push_data   = do_marker ? 32'hFFFF_FFFF : nonce_q[grant_idx];
    assign granted_vec = do_grant ? (NUM_CORES'(1) << grant_idx) : '0;
    assign found_run   = run_active ? core_found : '0;
    // A find on a slot whose old nonce is being enqueued this cycle is not a drop.
    assign drop_vec    = found_run & pending_q & ~granted_vec;
    assign pending_d   = (pending_q & ~granted_vec) | found_run;
    assign rr_d        = do_grant ? IW'((int'(grant_idx) + 1) % NUM_CORES) : rr_q;

`ifdef DROP_CNT_EN
    logic [15:0] drop_cnt_q;
    logic [4:0]  drop_inc;
    logic [16:0] drop_sum;
    always_comb begin
        drop_inc = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            drop_inc = drop_inc + 5'(drop_vec[i]);
        end
        drop_sum = {1'b0, drop_cnt_q} + 17'(drop_inc);
    end
    assign drop_count = drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (new_block) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`else
    logic unused_drop;
    assign unused_drop = ^drop_vec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            core_start_q <= '0;
            core_block_q <= '0;
            pending_q    <= '0;
            rr_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < NUM_CORES; i++) nonce_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            core_start_q <= '0;
            if (new_block) begin
                // Restart from any state. Pending results and queued words belong
                // to the old work unit and are discarded so they never reach the link.
                state_q      <= S_LOAD;
                core_block_q <= block;
                pending_q    <= '0;
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                count_q      <= '0;
            end else begin
                case (state_q)
                    S_IDLE:  ;
                    S_LOAD: begin
                        state_q      <= S_START;
                        core_start_q <= '1;
                    end
                    S_START: state_q <= S_RUN;
                    S_RUN:   if (do_marker) state_q <= S_DONE;
                    S_DONE:  ;
                    default: state_q <= S_IDLE;
                endcase

                pending_q <= pending_d;
                rr_q      <= rr_d;
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (found_run[i]) nonce_q[i] <= core_nonce[i*32 +: 32];
                end

                if (push) begin
                    mem_q[wr_ptr_q] <= push_data;
                    wr_ptr_q        <= wr_ptr_q + 1'b1;
                end
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push && !pop)      count_q <= count_q + 1'b1;
                else if (pop && !push) count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_work_scheduler.sv
module tb_work_scheduler;

    localparam int NC = 4;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              new_block;
    logic [351:0]      block;
    logic [NC-1:0]     core_start;
    logic [351:0]      core_block;
    logic [32*NC-1:0]  core_nonce_base;
    logic [NC-1:0]     core_found;
    logic [32*NC-1:0]  core_nonce;
    logic [NC-1:0]     core_done;
    logic              result_valid;
    logic [31:0]       result_data;
    logic              result_ready;
    logic [2:0]        state_dbg;
`ifdef DROP_CNT_EN
    logic [15:0]       drop_count;
`endif

    work_scheduler #(.NUM_CORES(NC), .FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .new_block       (new_block),
        .block           (block),
        .core_start      (core_start),
        .core_block      (core_block),
        .core_nonce_base (core_nonce_base),
        .core_found      (core_found),
        .core_nonce      (core_nonce),
        .core_done       (core_done),
        .result_valid    (result_valid),
        .result_data     (result_data),
        .result_ready    (result_ready),
        .state_dbg_o     (state_dbg)
`ifdef DROP_CNT_EN
        ,
        .drop_count      (drop_count)
`endif
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nonce(input int i, input logic [31:0] v);
        core_nonce[i*32 +: 32] = v;
    endtask

    typedef struct {
        logic [NC-1:0] found;
        logic          ready;
        logic          exp_valid;
        logic [31:0]   exp_data;
    } vec_t;

    vec_t        t3[5];
    logic [31:0] base_exp[NC];
    logic [351:0] blk_a, blk_b;
    int          seen;

    initial begin
        // tables
        base_exp[0] = 32'h0000_0000;
        base_exp[1] = 32'h4000_0000;
        base_exp[2] = 32'h8000_0000;
        base_exp[3] = 32'hC000_0000;
        t3[0] = '{found: 4'b1011, ready: 1'b1, exp_valid: 1'b0, exp_data: 32'd0};
        t3[1] = '{found: 4'b0000, ready: 1'b1, exp_valid: 1'b1, exp_data: 32'd10};
        t3[2] = '{found: 4'b0000, ready: 1'b1, exp_valid: 1'b1, exp_data: 32'd11};
        t3[3] = '{found: 4'b0000, ready: 1'b1, exp_valid: 1'b1, exp_data: 32'd13};
        t3[4] = '{found: 4'b0000, ready: 1'b1, exp_valid: 1'b0, exp_data: 32'd0};
        blk_a = {44{8'hA5}};
        blk_b = {44{8'h3C}};

        rst_n = 1'b0; new_block = 1'b0; block = '0; core_found = '0;
        core_nonce = '0; core_done = '0; result_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // reset state
        check32("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check32("rst_start", 32'(core_start), 32'd0);
        check32("rst_block_zero", 32'(core_block == '0), 32'd1);
        check32("rst_valid", 32'(result_valid), 32'd0);
        check32("rst_data", result_data, 32'd0);

        // T2: constant nonce bases
        for (int i = 0; i < NC; i++)
            check32($sformatf("base%0d", i), core_nonce_base[i*32 +: 32], base_exp[i]);

        // T1: load latency
        new_block = 1'b1; block = blk_a;
        tick();
        new_block = 1'b0; block = '0;
        check32("t1_block", 32'(core_block == blk_a), 32'd1);
        check32("t1_load_state", 32'(state_dbg), 32'(ST_LOAD));
        check32("t1_no_start_yet", 32'(core_start), 32'd0);
        tick();
        check32("t1_start", 32'(core_start), 32'hF);
        check32("t1_start_state", 32'(state_dbg), 32'(ST_START));
        tick();
        check32("t1_start_end", 32'(core_start), 32'd0);
        check32("t1_run_state", 32'(state_dbg), 32'(ST_RUN));

        // T3: simultaneous finds, round-robin order from rr=0
        set_nonce(0, 32'd10); set_nonce(1, 32'd11); set_nonce(2, 32'd0); set_nonce(3, 32'd13);
        for (int i = 0; i < 5; i++) begin
            core_found   = t3[i].found;
            result_ready = t3[i].ready;
            tick();
            check32($sformatf("t3_valid_%0d", i), 32'(result_valid), 32'(t3[i].exp_valid));
            if (t3[i].exp_valid)
                check32($sformatf("t3_data_%0d", i), result_data, t3[i].exp_data);
        end
        core_found = '0;

        // T4: FIFO fills, pending holds one, sixth find overwrites fifth
        result_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            set_nonce(2, 32'h200 + 32'(k));
            core_found = 4'b0100;
            tick();
            core_found = '0;
            tick();
            tick();
        end
        check32("t4_valid_full", 32'(result_valid), 32'd1);
        check32("t4_head_stable", result_data, 32'h201);
`ifdef DROP_CNT_EN
        check32("t4_drop_count", 32'(drop_count), 32'd1);
`endif
        exp_q = '{32'h201, 32'h202, 32'h203, 32'h204, 32'h206};
        result_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (result_valid) begin
                if (exp_q.size() == 0) check32("t4_extra_word", result_data, 32'hDEAD_BEEF);
                else check32("t4_order", result_data, exp_q.pop_front());
            end
            tick();
        end
        check32("t4_all_delivered", 32'(exp_q.size()), 32'd0);
        check32("t4_drained", 32'(result_valid), 32'd0);

        // T5: exhaustion marker, exactly once
        result_ready = 1'b0;
        core_done = 4'hF;
        tick();
        check32("t5_state_done", 32'(state_dbg), 32'(ST_DONE));
        check32("t5_valid", 32'(result_valid), 32'd1);
        check32("t5_marker", result_data, 32'hFFFF_FFFF);
        result_ready = 1'b1;
        tick();
        check32("t5_popped", 32'(result_valid), 32'd0);
        tick(); tick();
        check32("t5_once", 32'(result_valid), 32'd0);
        check32("t5_stay_done", 32'(state_dbg), 32'(ST_DONE));
        core_done = '0;
        result_ready = 1'b0;

        // T6: new_block discards queued and pending results
        new_block = 1'b1; block = blk_b;
        tick();
        new_block = 1'b0;
        tick(); tick();
        check32("t6_run", 32'(state_dbg), 32'(ST_RUN));
        set_nonce(0, 32'h61); set_nonce(1, 32'h62);
        core_found = 4'b0011;
        tick();
        core_found = '0;
        tick(); tick(); tick();
        check32("t6_queued_head", result_data, 32'h61);
        new_block = 1'b1;
        set_nonce(3, 32'hBAD0); core_found = 4'b1000;
        tick();
        new_block = 1'b0;
        check32("t6_flush_valid", 32'(result_valid), 32'd0);
        check32("t6_flush_data", result_data, 32'd0);
        check32("t6_load", 32'(state_dbg), 32'(ST_LOAD));
        check32("t6_block", 32'(core_block == blk_b), 32'd1);
        set_nonce(3, 32'hBAD1); core_found = 4'b1000;
        tick();
        check32("t6_start", 32'(core_start), 32'hF);
        set_nonce(2, 32'hBAD2); core_found = 4'b0100;
        tick();
        core_found = '0;
        result_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (result_valid) seen++;
            tick();
        end
        check32("t6_no_stale", 32'(seen), 32'd0);

        // reset mid-operation
        result_ready = 1'b0;
        set_nonce(0, 32'h77); core_found = 4'b0001;
        tick();
        core_found = '0;
        tick(); tick();
        check32("rst_mid_pre", 32'(result_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check32("rst_mid_valid", 32'(result_valid), 32'd0);
        check32("rst_mid_state", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (core_start != '0) seen++;
        end
        check32("rst_mid_no_start", 32'(seen), 32'd0);
        check32("rst_mid_idle", 32'(state_dbg), 32'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
